// File: rtl/cache_way_lookup.sv
// Tag lookup and FIFO replacement core for a 2-way set-associative cache.
// Partial (halt) tags are compared for every index; the indexed result gates the main-tag compare.
module cache_way_lookup #(
  parameter int NUM_IDX = 8,
  parameter int HALT_W  = 4,
  parameter int MAIN_W  = 20,
  parameter int IDX_W   = $clog2(NUM_IDX)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [IDX_W-1:0]          addr_index,
  input  logic [HALT_W-1:0]         addr_halt,
  input  logic [MAIN_W-1:0]         addr_main,
  input  logic [NUM_IDX*HALT_W-1:0] w0_halt_tags,
  input  logic [NUM_IDX*HALT_W-1:0] w1_halt_tags,
  input  logic [MAIN_W-1:0]         w0_main_tag,
  input  logic [MAIN_W-1:0]         w1_main_tag,
  input  logic                      w0_valid,
  input  logic                      w1_valid,
  output logic [NUM_IDX-1:0]        w0_halt_eq,
  output logic [NUM_IDX-1:0]        w1_halt_eq,
  output logic                      way_hit0,
  output logic                      way_hit1,
  output logic                      hit,
  output logic                      rd_way,
  output logic                      repl_way
);

  logic               eq_idx_w0;
  logic               eq_idx_w1;
  logic               main_hit_w0;
  logic               main_hit_w1;
  logic [NUM_IDX-1:0] ptr;
  logic [NUM_IDX-1:0] ptr_next;

  // Every index is compared in parallel so the halt result is ready before the index mux settles.
  for (genvar i = 0; i < NUM_IDX; i++) begin : g_halt_cmp
    assign w0_halt_eq[i] = (addr_halt == w0_halt_tags[i*HALT_W +: HALT_W]);
    assign w1_halt_eq[i] = (addr_halt == w1_halt_tags[i*HALT_W +: HALT_W]);
  end

  assign eq_idx_w0 = w0_halt_eq[addr_index];
  assign eq_idx_w1 = w1_halt_eq[addr_index];

  // The halt match acts as the enable of the wide compare: a disabled compare reports no match.
  assign main_hit_w0 = eq_idx_w0 & (addr_main == w0_main_tag);
  assign main_hit_w1 = eq_idx_w1 & (addr_main == w1_main_tag);

  assign way_hit0 = main_hit_w0 & w0_valid;
  assign way_hit1 = main_hit_w1 & w1_valid;
  assign hit      = way_hit0 | way_hit1;
  // If both ways ever hit (corrupt tag state), way1 is selected deterministically.
  assign rd_way   = hit & way_hit1;

  assign repl_way = ptr[addr_index];

  // NOTE: assign the default first so every path writes ptr_next and no latch is inferred.
  always_comb begin
    ptr_next = ptr;
    if (!hit) begin
      ptr_next[addr_index] = ~ptr[addr_index];
    end
  end

  // Hits never move the pointer: replacement is FIFO, not LRU.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the pointer array is only NUM_IDX flops, so it is reset; large tag/data RAMs are not.
      ptr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      ptr <= ptr_next;
    end
  end

endmodule

// File: tb/tb_cache_way_lookup.sv
// Directed bench for cache_way_lookup: table of combinational lookup vectors plus
// hand-written sequences for the FIFO pointer behaviour.
module tb_cache_way_lookup;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  addr_index;
  logic [3:0]  addr_halt;
  logic [19:0] addr_main;
  logic [31:0] w0_halt_tags;
  logic [31:0] w1_halt_tags;
  logic [19:0] w0_main_tag;
  logic [19:0] w1_main_tag;
  logic        w0_valid;
  logic        w1_valid;
  logic [7:0]  w0_halt_eq;
  logic [7:0]  w1_halt_eq;
  logic        way_hit0;
  logic        way_hit1;
  logic        hit;
  logic        rd_way;
  logic        repl_way;

  int n_cmp = 0;
  int n_bad = 0;

  cache_way_lookup dut (
    .clk          (clk),
    .reset        (reset),
    .addr_index   (addr_index),
    .addr_halt    (addr_halt),
    .addr_main    (addr_main),
    .w0_halt_tags (w0_halt_tags),
    .w1_halt_tags (w1_halt_tags),
    .w0_main_tag  (w0_main_tag),
    .w1_main_tag  (w1_main_tag),
    .w0_valid     (w0_valid),
    .w1_valid     (w1_valid),
    .w0_halt_eq   (w0_halt_eq),
    .w1_halt_eq   (w1_halt_eq),
    .way_hit0     (way_hit0),
    .way_hit1     (way_hit1),
    .hit          (hit),
    .rd_way       (rd_way),
    .repl_way     (repl_way)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  idx;
    logic [3:0]  halt;
    logic [19:0] main;
    logic [31:0] t0;
    logic [31:0] t1;
    logic [19:0] m0;
    logic [19:0] m1;
    logic        v0;
    logic        v1;
    logic [7:0]  e_eq0;
    logic [7:0]  e_eq1;
    logic        e_h0;
    logic        e_h1;
    logic        e_hit;
    logic        e_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] idx, input logic [3:0] halt, input logic [19:0] main,
                       input logic [31:0] t0, input logic [31:0] t1,
                       input logic [19:0] m0, input logic [19:0] m1,
                       input logic v0, input logic v1);
    addr_index   = idx;
    addr_halt    = halt;
    addr_main    = main;
    w0_halt_tags = t0;
    w1_halt_tags = t1;
    w0_main_tag  = m0;
    w1_main_tag  = m1;
    w0_valid     = v0;
    w1_valid     = v1;
    #1;
  endtask

  initial begin
    // idx, halt, main, t0, t1, m0, m1, v0, v1, eq0, eq1, h0, h1, hit, rd
    vecs[0] = '{3'd3, 4'h0, 20'h00A00, 32'h0000_0000, 32'h1111_1111, 20'h00A00, 20'h00000, 1, 1, 8'hFF, 8'h00, 1, 0, 1, 0};
    vecs[1] = '{3'd3, 4'h0, 20'h00A00, 32'h1111_1111, 32'h0000_0000, 20'h00A00, 20'h00A00, 1, 1, 8'h00, 8'hFF, 0, 1, 1, 1};
    vecs[2] = '{3'd3, 4'h0, 20'h00A00, 32'h1111_1111, 32'h0000_0000, 20'h00A00, 20'h00A01, 1, 1, 8'h00, 8'hFF, 0, 0, 0, 0};
    vecs[3] = '{3'd3, 4'h0, 20'h00A00, 32'h0000_0000, 32'h0000_0000, 20'h00A00, 20'h00A00, 0, 0, 8'hFF, 8'hFF, 0, 0, 0, 0};
    vecs[4] = '{3'd3, 4'h0, 20'h00A00, 32'h7654_3210, 32'hFEDC_BA98, 20'h00A00, 20'h00A00, 1, 1, 8'h01, 8'h00, 0, 0, 0, 0};
    vecs[5] = '{3'd0, 4'h0, 20'h00A00, 32'h7654_3210, 32'hFEDC_BA98, 20'h00A00, 20'h00A00, 1, 1, 8'h01, 8'h00, 1, 0, 1, 0};
    vecs[6] = '{3'd7, 4'h7, 20'h12345, 32'hFEDC_BA98, 32'h7654_3210, 20'h12345, 20'h12345, 1, 1, 8'h00, 8'h80, 0, 1, 1, 1};
    vecs[7] = '{3'd3, 4'h0, 20'h00A00, 32'h0000_0000, 32'h0000_0000, 20'h00A00, 20'h00A00, 1, 1, 8'hFF, 8'hFF, 1, 1, 1, 1};
    vecs[8] = '{3'd6, 4'hB, 20'hABCDA, 32'h7654_3210, 32'hFEDC_BA98, 20'hABCDA, 20'hABCDA, 1, 1, 8'h00, 8'h08, 0, 0, 0, 0};

    reset = 1'b1;
    drive(3'd0, 4'h0, 20'h0, 32'h0, 32'h0, 20'h0, 20'h0, 0, 0);
    tick();

    // Reset state: every index points at way0, nothing valid.
    for (int i = 0; i < 8; i++) begin
      addr_index = 3'(i);
      #1;
      check($sformatf("rst_repl_idx%0d", i), 32'(repl_way), 32'd0);
    end
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_rd_way", 32'(rd_way), 32'd0);

    // Combinational vectors, held in reset so pointer state is untouched.
    for (int v = 0; v < 9; v++) begin
      drive(vecs[v].idx, vecs[v].halt, vecs[v].main, vecs[v].t0, vecs[v].t1,
            vecs[v].m0, vecs[v].m1, vecs[v].v0, vecs[v].v1);
      check($sformatf("v%0d_w0_halt_eq", v), 32'(w0_halt_eq), 32'(vecs[v].e_eq0));
      check($sformatf("v%0d_w1_halt_eq", v), 32'(w1_halt_eq), 32'(vecs[v].e_eq1));
      check($sformatf("v%0d_way_hit0", v), 32'(way_hit0), 32'(vecs[v].e_h0));
      check($sformatf("v%0d_way_hit1", v), 32'(way_hit1), 32'(vecs[v].e_h1));
      check($sformatf("v%0d_hit", v), 32'(hit), 32'(vecs[v].e_hit));
      check($sformatf("v%0d_rd_way", v), 32'(rd_way), 32'(vecs[v].e_rd));
      check($sformatf("v%0d_repl_way", v), 32'(repl_way), 32'd0);
      tick();
    end

    // Index 3 miss sequence: toggle per miss edge, hold on hit.
    reset = 1'b0;
    drive(3'd3, 4'h0, 20'h00A00, 32'h0, 32'h0, 20'h00A00, 20'h00A00, 0, 0);
    check("idx3_repl_start", 32'(repl_way), 32'd0);
    tick();
    check("idx3_repl_miss1", 32'(repl_way), 32'd1);
    w0_valid = 1'b1;
    #1;
    check("idx3_hit", 32'(hit), 32'd1);
    tick();
    check("idx3_repl_after_hit", 32'(repl_way), 32'd1);
    w0_valid = 1'b0;
    tick();
    check("idx3_repl_miss2", 32'(repl_way), 32'd0);
    addr_index = 3'd5;
    #1;
    check("idx5_repl_untouched", 32'(repl_way), 32'd0);

    // addr 0xABCDABC0: idx6 miss then fill, pointer must stay at 1.
    drive(3'd6, 4'hB, 20'hABCDA, 32'h7654_3210, 32'hFEDC_BA98, 20'hABCDA, 20'hABCDA, 1, 1);
    check("idx6_miss_hit", 32'(hit), 32'd0);
    check("idx6_repl_start", 32'(repl_way), 32'd0);
    tick();
    check("idx6_repl_after_miss", 32'(repl_way), 32'd1);
    w0_halt_tags = 32'h7B54_3210;  // fill: way0 index 6 now holds halt tag 0xB
    #1;
    check("idx6_fill_hit", 32'(way_hit0), 32'd1);
    tick();
    check("idx6_repl_hold1", 32'(repl_way), 32'd1);
    tick();
    check("idx6_repl_hold2", 32'(repl_way), 32'd1);

    // Reset during a miss on idx2 (pointer 0): must stay 0, idx6 cleared.
    drive(3'd2, 4'h0, 20'h00A00, 32'h0, 32'h0, 20'h00A00, 20'h00A00, 0, 0);
    reset = 1'b1;
    tick();
    check("rst_mid_miss_idx2", 32'(repl_way), 32'd0);
    addr_index = 3'd6;
    #1;
    check("rst_mid_miss_idx6", 32'(repl_way), 32'd0);
    addr_index = 3'd3;
    #1;
    check("rst_mid_miss_idx3", 32'(repl_way), 32'd0);

    // Both ways hitting after reset release: way1 wins, no pointer movement.
    reset = 1'b0;
    w0_valid = 1'b1;
    w1_valid = 1'b1;
    #1;
    check("both_hit_hit", 32'(hit), 32'd1);
    check("both_hit_rd_way", 32'(rd_way), 32'd1);
    tick();
    check("both_hit_repl", 32'(repl_way), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
